logit_frame_collector: RTL and testbench

Producer-side front end for the classifier argmax stage. Accepts signed class logits one per beat from the fully-connected layer over a valid/ready stream and assembles them into a frame of NUM_CLASSES scores. Presents each complete frame as a parallel bus, with a valid/ready handshake, to the registered argmax stage. Slot k of the bus carries class index k.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/logit_frame_collector.sv | 120 ++++++++++++
 tb/tb_logit_frame_collector.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the classifier tail: class count, logit format and
// the collector state encoding.
package cnn_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int LOGIT_W     = 62;
   localparam int CLASS_IDX_W = 4;

   typedef logic signed [LOGIT_W-1:0] logit_t;
   typedef logic [CLASS_IDX_W-1:0]    class_idx_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } collector_state_e;

   // Most-negative logit; a padded slot can never win the argmax.
   localparam logit_t LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};

endpackage

// File: rtl/logit_frame_collector.sv
// Collects NUM_CLASSES signed logits arriving one per beat and presents the
// complete frame as a parallel bus to the argmax stage. Short frames are
// padded with the most-negative value and flagged in a sticky error bit.
module logit_frame_collector #(
   parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
   parameter int DATA_W      = cnn_pkg::LOGIT_W,
   parameter int IDX_W       = cnn_pkg::CLASS_IDX_W,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic signed [DATA_W-1:0]      s_data,
   input  logic                          s_last,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [NUM_CLASSES*DATA_W-1:0] m_scores,
   output logic                          frame_err,
   output logic [CNT_W-1:0]              frame_cnt
);

   import cnn_pkg::collector_state_e;
   import cnn_pkg::FILL;
   import cnn_pkg::FULL;

   localparam logic [DATA_W-1:0] PAD_VALUE = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

   collector_state_e  state_q, state_d;
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0] slot_q [NUM_CLASSES];
   logic [DATA_W-1:0] slot_d [NUM_CLASSES];
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Next-state, slot writes, padding and hand-off bookkeeping.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      for (int j = 0; j < NUM_CLASSES; j++) begin
         slot_d[j] = slot_q[j];
      end

      unique case (state_q)
         FILL: begin
            if (s_valid) begin
               for (int j = 0; j < NUM_CLASSES; j++) begin
                  if (j == int'(wr_ptr_q)) begin
                     slot_d[j] = s_data;
                  end
               end
               if (wr_ptr_q == LAST_IDX) begin
                  state_d = FULL;
                  if (!s_last) begin
                     err_d = 1'b1;
                  end
               end else if (s_last) begin
                  for (int j = 0; j < NUM_CLASSES; j++) begin
                     if (j > int'(wr_ptr_q)) begin
                        slot_d[j] = PAD_VALUE;
                     end
                  end
                  err_d   = 1'b1;
                  state_d = FULL;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (m_ready) begin
               state_d  = FILL;
               wr_ptr_d = '0;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State, pointer, slot bank and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         wr_ptr_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         for (int j = 0; j < NUM_CLASSES; j++) begin
            slot_q[j] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         for (int j = 0; j < NUM_CLASSES; j++) begin
            slot_q[j] <= slot_d[j];
         end
      end
   end

   // Flatten the slot bank onto the output bus, slot k at bits k*DATA_W.
   always_comb begin
      m_scores = '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
         m_scores[k*DATA_W +: DATA_W] = slot_q[k];
      end
   end

   assign s_ready   = (state_q == FILL);
   assign m_valid   = (state_q == FULL);
   assign frame_err = err_q;
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_logit_frame_collector.sv
// Directed bench for logit_frame_collector: normal, backpressure, short,
// missing-last, mid-frame reset and gapped-input frames.
module tb_logit_frame_collector;

   localparam int NC = 10;
   localparam int DW = 62;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  s_valid;
   logic                  s_ready;
   logic signed [DW-1:0]  s_data;
   logic                  s_last;
   logic                  m_valid;
   logic                  m_ready;
   logic [NC*DW-1:0]      m_scores;
   logic                  frame_err;
   logic [15:0]           frame_cnt;

   int total = 0;
   int bad   = 0;

   logic signed [DW-1:0] norm_vals [NC] = '{-5, 3, 100, -1, 7, 0, 2, 99, -100, 4};
   logic signed [DW-1:0] exp_s [NC];
   logic [DW-1:0]        pad_val = 62'h2000_0000_0000_0000;

   logit_frame_collector dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_scores  (m_scores),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic signed [DW-1:0] get_slot(input int k);
      return m_scores[k*DW +: DW];
   endfunction

   task automatic reset_dut();
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send_beat(input logic signed [DW-1:0] d, input logic last);
      int waited = 0;
      s_valid = 1'b1; s_data = d; s_last = last;
      while (!s_ready && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!s_ready) begin
         total++; bad++;
         $display("[TB] FAIL beat_timeout s_ready=%0b required 1", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic accept_frame();
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_ready got %0b want 1", s_ready); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got %0b want 0", m_valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got %0b want 0", frame_err); end
      total++; if (frame_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got %0d want 0", frame_cnt); end
      total++; if (m_scores !== '0) begin bad++; $display("[TB] FAIL reset_scores got %h want 0", m_scores); end
   endtask

   task automatic test_normal();
      m_ready = 1'b1;
      for (int k = 0; k < NC - 1; k++) send_beat(norm_vals[k], 1'b0);
      total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL normal_early_valid got %0b want 0", m_valid); end
      send_beat(norm_vals[NC-1], 1'b1);
      total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL normal_valid got %0b want 1", m_valid); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL normal_s_ready got %0b want 0", s_ready); end
      for (int k = 0; k < NC; k++) begin
         total++;
         if (get_slot(k) !== norm_vals[k]) begin bad++; $display("[TB] FAIL normal_slot%0d got %0d want %0d", k, get_slot(k), norm_vals[k]); end
      end
      total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL normal_err got %0b want 0", frame_err); end
      total++; if (frame_cnt !== 16'd0) begin bad++; $display("[TB] FAIL normal_cnt_before got %0d want 0", frame_cnt); end
      @(posedge clk); #1;
      m_ready = 1'b0;
      total++; if (frame_cnt !== 16'd1) begin bad++; $display("[TB] FAIL normal_cnt_after got %0d want 1", frame_cnt); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL normal_valid_drop got %0b want 0", m_valid); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL normal_ready_back got %0b want 1", s_ready); end
   endtask

   task automatic test_backpressure();
      logic [NC*DW-1:0] exp_bus;
      m_ready = 1'b0;
      for (int k = 0; k < NC; k++) begin
         exp_bus[k*DW +: DW] = DW'(1000 + k);
         send_beat(DW'(1000 + k), k == NC - 1);
      end
      s_valid = 1'b1; s_data = 62'sd77; s_last = 1'b0;
      for (int c = 0; c < 20; c++) begin
         total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_s_ready cycle%0d got %0b want 0", c, s_ready); end
         total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_m_valid cycle%0d got %0b want 1", c, m_valid); end
         total++; if (m_scores !== exp_bus) begin bad++; $display("[TB] FAIL bp_scores cycle%0d got %h want %h", c, m_scores, exp_bus); end
         @(posedge clk); #1;
      end
      accept_frame();
      total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_after got %0b want 1", s_ready); end
      total++; if (frame_cnt !== 16'd2) begin bad++; $display("[TB] FAIL bp_cnt got %0d want 2", frame_cnt); end
      @(posedge clk); #1;
      s_valid = 1'b0;
      total++; if (get_slot(0) !== 62'sd77) begin bad++; $display("[TB] FAIL bp_slot0 got %0d want 77", get_slot(0)); end
      total++; if (get_slot(1) !== 62'sd1001) begin bad++; $display("[TB] FAIL bp_slot1_kept got %0d want 1001", get_slot(1)); end
      for (int k = 1; k < NC; k++) send_beat(DW'(200 + k), k == NC - 1);
      total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp2_valid got %0b want 1", m_valid); end
      total++; if (get_slot(0) !== 62'sd77) begin bad++; $display("[TB] FAIL bp2_slot0 got %0d want 77", get_slot(0)); end
      total++; if (get_slot(5) !== 62'sd205) begin bad++; $display("[TB] FAIL bp2_slot5 got %0d want 205", get_slot(5)); end
      accept_frame();
      total++; if (frame_cnt !== 16'd3) begin bad++; $display("[TB] FAIL bp2_cnt got %0d want 3", frame_cnt); end
   endtask

   task automatic test_short_frame();
      exp_s[0] = 62'sd10; exp_s[1] = -62'sd2; exp_s[2] = 62'sd30; exp_s[3] = 62'sd5;
      for (int k = 4; k < NC; k++) exp_s[k] = pad_val;
      for (int k = 0; k < 4; k++) send_beat(exp_s[k], k == 3);
      total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL short_valid got %0b want 1", m_valid); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL short_err got %0b want 1", frame_err); end
      for (int k = 0; k < NC; k++) begin
         total++;
         if (get_slot(k) !== exp_s[k]) begin bad++; $display("[TB] FAIL short_slot%0d got %h want %h", k, get_slot(k), exp_s[k]); end
      end
      accept_frame();
      total++; if (frame_cnt !== 16'd4) begin bad++; $display("[TB] FAIL short_cnt got %0d want 4", frame_cnt); end
   endtask

   task automatic test_missing_last();
      reset_dut();
      for (int k = 0; k < NC; k++) begin
         exp_s[k] = DW'(k * 11 - 50);
         send_beat(exp_s[k], 1'b0);
      end
      total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL nolast_valid got %0b want 1", m_valid); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL nolast_err got %0b want 1", frame_err); end
      for (int k = 0; k < NC; k++) begin
         total++;
         if (get_slot(k) !== exp_s[k]) begin bad++; $display("[TB] FAIL nolast_slot%0d got %0d want %0d", k, get_slot(k), exp_s[k]); end
      end
      accept_frame();
      total++; if (frame_cnt !== 16'd1) begin bad++; $display("[TB] FAIL nolast_cnt got %0d want 1", frame_cnt); end
      for (int k = 0; k < NC; k++) begin
         exp_s[k] = DW'(-(k + 1) * 1000);
         send_beat(exp_s[k], k == NC - 1);
      end
      total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL nolast2_valid got %0b want 1", m_valid); end
      for (int k = 0; k < NC; k++) begin
         total++;
         if (get_slot(k) !== exp_s[k]) begin bad++; $display("[TB] FAIL nolast2_slot%0d got %0d want %0d", k, get_slot(k), exp_s[k]); end
      end
      accept_frame();
      total++; if (frame_cnt !== 16'd2) begin bad++; $display("[TB] FAIL nolast2_cnt got %0d want 2", frame_cnt); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL nolast2_err_sticky got %0b want 1", frame_err); end
   endtask

   task automatic test_reset_mid_frame();
      reset_dut();
      for (int k = 0; k < 5; k++) send_beat(norm_vals[k], 1'b0);
      reset_dut();
      total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got %0b want 0", m_valid); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready got %0b want 1", s_ready); end
      total++; if (m_scores !== '0) begin bad++; $display("[TB] FAIL midrst_scores got %h want 0", m_scores); end
      total++; if (frame_cnt !== 16'd0) begin bad++; $display("[TB] FAIL midrst_cnt got %0d want 0", frame_cnt); end
      for (int k = 0; k < NC; k++) send_beat(norm_vals[k], k == NC - 1);
      total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst2_valid got %0b want 1", m_valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst2_err got %0b want 0", frame_err); end
      for (int k = 0; k < NC; k++) begin
         total++;
         if (get_slot(k) !== norm_vals[k]) begin bad++; $display("[TB] FAIL midrst2_slot%0d got %0d want %0d", k, get_slot(k), norm_vals[k]); end
      end
      accept_frame();
      total++; if (frame_cnt !== 16'd1) begin bad++; $display("[TB] FAIL midrst2_cnt got %0d want 1", frame_cnt); end
   endtask

   task automatic test_gapped_input();
      logic [63:0] raw;
      int gap;
      reset_dut();
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < NC; k++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
               s_valid = 1'b0;
               @(posedge clk); #1;
            end
            raw = {$urandom, $urandom};
            exp_s[k] = raw[DW-1:0];
            send_beat(exp_s[k], k == NC - 1);
         end
         total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_f%0d_valid got %0b want 1", f, m_valid); end
         for (int k = 0; k < NC; k++) begin
            total++;
            if (get_slot(k) !== exp_s[k]) begin bad++; $display("[TB] FAIL gap_f%0d_slot%0d got %h want %h", f, k, get_slot(k), exp_s[k]); end
         end
         repeat (int'($urandom_range(0, 3))) @(posedge clk);
         #1 accept_frame();
      end
      total++; if (frame_cnt !== 16'd3) begin bad++; $display("[TB] FAIL gap_cnt got %0d want 3", frame_cnt); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL gap_err got %0b want 0", frame_err); end
   endtask

   initial begin
      void'($urandom(32'd20240611));
      test_reset();
      test_normal();
      test_backpressure();
      test_short_frame();
      test_missing_last();
      test_reset_mid_frame();
      test_gapped_input();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

endmodule
